// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared constants for the multicycle control unit: decoded op
//               codes, 5-bit opcode field values and the step-counter ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Highest legal step value; anything above it wraps the counter to fetch.
    localparam logic [2:0] DEF_MAX_STEP = 3'd4;

    // Decoded op codes presented on Op.
    localparam logic [5:0] OP_ILLEGAL = 6'h00;
    localparam logic [5:0] OP_LHI     = 6'h01;
    localparam logic [5:0] OP_LLI     = 6'h02;
    localparam logic [5:0] OP_LDRRI   = 6'h03;
    localparam logic [5:0] OP_LDRRR   = 6'h04;
    localparam logic [5:0] OP_STRRI   = 6'h05;
    localparam logic [5:0] OP_STRRR   = 6'h06;
    localparam logic [5:0] OP_ADD     = 6'h07;
    localparam logic [5:0] OP_ADC     = 6'h08;
    localparam logic [5:0] OP_SUB     = 6'h09;
    localparam logic [5:0] OP_SBB     = 6'h0A;
    localparam logic [5:0] OP_CMP     = 6'h0B;
    localparam logic [5:0] OP_ADDI    = 6'h0C;
    localparam logic [5:0] OP_SUBI    = 6'h0D;
    localparam logic [5:0] OP_MOV     = 6'h0E;
    localparam logic [5:0] OP_BCC     = 6'h0F;
    localparam logic [5:0] OP_BCS     = 6'h10;
    localparam logic [5:0] OP_BEQ     = 6'h11;
    localparam logic [5:0] OP_BNE     = 6'h12;
    localparam logic [5:0] OP_BAL     = 6'h13;
    localparam logic [5:0] OP_JMP     = 6'h14;
    localparam logic [5:0] OP_JALRL   = 6'h15;
    localparam logic [5:0] OP_JALRR   = 6'h16;
    localparam logic [5:0] OP_JR      = 6'h17;
    localparam logic [5:0] OP_OUTR    = 6'h18;
    localparam logic [5:0] OP_HLT     = 6'h19;

    // Values of the IR[15:11] opcode field.
    localparam logic [4:0] OPC_ALU    = 5'b00000;
    localparam logic [4:0] OPC_LHI    = 5'b00001;
    localparam logic [4:0] OPC_LLI    = 5'b00010;
    localparam logic [4:0] OPC_LDRRI  = 5'b00011;
    localparam logic [4:0] OPC_LDRRR  = 5'b00100;
    localparam logic [4:0] OPC_STRRI  = 5'b00101;
    localparam logic [4:0] OPC_STRCMP = 5'b00110;
    localparam logic [4:0] OPC_ADDI   = 5'b00111;
    localparam logic [4:0] OPC_SUBI   = 5'b01000;
    localparam logic [4:0] OPC_MOV    = 5'b01011;
    localparam logic [4:0] OPC_BCOND  = 5'b11000;
    localparam logic [4:0] OPC_BAL    = 5'b11001;
    localparam logic [4:0] OPC_JMP    = 5'b10000;
    localparam logic [4:0] OPC_JALRL  = 5'b10001;
    localparam logic [4:0] OPC_JALRR  = 5'b10010;
    localparam logic [4:0] OPC_JR     = 5'b10011;
    localparam logic [4:0] OPC_SYS    = 5'b11100;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_op_decode
// Description : Combinational instruction decoder. Maps the latched IR fields
//               to the 6-bit Op code and the final step of the instruction.
// Ports       : ins_m_i    IR[15:11] opcode field
//               cond_i     IR[10:8]  branch condition
//               ins_l_i    IR[1:0]   function sub-field
//               op_o       decoded op code (00 = illegal)
//               end_step_o step value at which the instruction completes
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_op_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] ins_m_i,
    input  logic [2:0] cond_i,
    input  logic [1:0] ins_l_i,
    output logic [5:0] op_o,
    output logic [2:0] end_step_o
);

    always_comb begin
        op_o = OP_ILLEGAL;
        case (ins_m_i)
            OPC_LHI:    op_o = OP_LHI;
            OPC_LLI:    op_o = OP_LLI;
            OPC_LDRRI:  op_o = OP_LDRRI;
            OPC_LDRRR:  op_o = OP_LDRRR;
            OPC_STRRI:  op_o = OP_STRRI;
            OPC_STRCMP: begin
                if (ins_l_i == 2'b00)      op_o = OP_STRRR;
                else if (ins_l_i == 2'b01) op_o = OP_CMP;
            end
            OPC_ALU: begin
                case (ins_l_i)
                    2'b00:   op_o = OP_ADD;
                    2'b01:   op_o = OP_ADC;
                    2'b10:   op_o = OP_SUB;
                    default: op_o = OP_SBB;
                endcase
            end
            OPC_ADDI:   op_o = OP_ADDI;
            OPC_SUBI:   op_o = OP_SUBI;
            OPC_MOV:    op_o = OP_MOV;
            OPC_BCOND: begin
                case (cond_i)
                    3'b011:  op_o = OP_BCC;
                    3'b010:  op_o = OP_BCS;
                    3'b001:  op_o = OP_BEQ;
                    3'b000:  op_o = OP_BNE;
                    default: op_o = OP_ILLEGAL;
                endcase
            end
            OPC_BAL:    op_o = OP_BAL;
            OPC_JMP:    op_o = OP_JMP;
            OPC_JALRL:  op_o = OP_JALRL;
            OPC_JALRR:  op_o = OP_JALRR;
            OPC_JR:     op_o = OP_JR;
            OPC_SYS: begin
                if (ins_l_i == 2'b00)      op_o = OP_OUTR;
                else if (ins_l_i == 2'b01) op_o = OP_HLT;
            end
            default:    op_o = OP_ILLEGAL;
        endcase
    end

    // Loads need an extra memory step; ALU, store and link ops need a
    // write-back step; everything else (including illegal) is done at step 2.
    always_comb begin
        end_step_o = 3'd2;
        case (op_o)
            OP_LDRRI, OP_LDRRR: end_step_o = 3'd4;
            OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP, OP_ADDI, OP_SUBI,
            OP_STRRI, OP_STRRR, OP_JALRL, OP_JALRR: end_step_o = 3'd3;
            default: end_step_o = 3'd2;
        endcase
    end

endmodule : ctrl_op_decode
`default_nettype wire

// File: rtl/ctrl_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_step_sequencer
// Description : Step counter, instruction register and halt state of the
//               multicycle control unit.
// Ports       : clk      system clock, rising edge
//               Rst      asynchronous active-high reset
//               MemData  instruction word, sampled while Cnt==0
//               Stall    memory wait, freezes all state
//               Cnt      current step (0 fetch, 1 decode, ...)
//               InsM     IR[15:11]    InsL  IR[1:0]    Cond  IR[10:8]
//               Op       decoded op code (00 = illegal)
//               LastStep final step of the current instruction
//               Halted   set once HLT completes, cleared only by Rst
//               Illegal  illegal op code in steps >= 1
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_step_sequencer
    import ctrl_pkg::*;
#(
    parameter logic [2:0] MAX_STEP = DEF_MAX_STEP
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [15:0] MemData,
    input  logic        Stall,
    output logic [2:0]  Cnt,
    output logic [4:0]  InsM,
    output logic [1:0]  InsL,
    output logic [2:0]  Cond,
    output logic [5:0]  Op,
    output logic        LastStep,
    output logic        Halted,
    output logic        Illegal
);

    logic [2:0]  cnt_q,    cnt_d;
    logic [15:0] ir_q,     ir_d;
    logic        halted_q, halted_d;
    logic [5:0]  op;
    logic [2:0]  end_step;
    logic        last_step;

    ctrl_op_decode u_op_decode (
        .ins_m_i    (ir_q[15:11]),
        .cond_i     (ir_q[10:8]),
        .ins_l_i    (ir_q[1:0]),
        .op_o       (op),
        .end_step_o (end_step)
    );

    // Step 0 is always fetch, so it can never be a final step.
    assign last_step = (cnt_q != 3'd0) && (cnt_q == end_step) && !halted_q;

    always_comb begin
        cnt_d    = cnt_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        if (!halted_q && !Stall) begin
            if (cnt_q == 3'd0) begin
                ir_d = MemData;
            end
            if (last_step) begin
                cnt_d = 3'd0;
                if (op == OP_HLT) begin
                    halted_d = 1'b1;
                end
            end else if (cnt_q >= MAX_STEP) begin
                cnt_d = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            cnt_q    <= 3'd0;
            ir_q     <= 16'h0000;
            halted_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    // IR[7:2] is latched with the word but not consumed by this stage.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[7:2];

    assign Cnt      = cnt_q;
    assign InsM     = ir_q[15:11];
    assign InsL     = ir_q[1:0];
    assign Cond     = ir_q[10:8];
    assign Op       = op;
    assign LastStep = last_step;
    assign Halted   = halted_q;
    assign Illegal  = (op == OP_ILLEGAL) && (cnt_q != 3'd0);

endmodule : ctrl_step_sequencer
`default_nettype wire

// File: tb/tb_ctrl_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_step_sequencer
// Description : Self-checking bench for ctrl_step_sequencer. Directed
//               instruction sequences followed by random instruction words
//               and stalls, checked against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_step_sequencer;

    logic        clk = 1'b0;
    logic        Rst;
    logic [15:0] MemData;
    logic        Stall;
    logic [2:0]  Cnt;
    logic [4:0]  InsM;
    logic [1:0]  InsL;
    logic [2:0]  Cond;
    logic [5:0]  Op;
    logic        LastStep;
    logic        Halted;
    logic        Illegal;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: step number, latched word, halt flag.
    int          m_cnt;
    logic [15:0] m_ir;
    logic        m_halted;

    always #5 clk = ~clk;

    ctrl_step_sequencer dut (
        .clk      (clk),
        .Rst      (Rst),
        .MemData  (MemData),
        .Stall    (Stall),
        .Cnt      (Cnt),
        .InsM     (InsM),
        .InsL     (InsL),
        .Cond     (Cond),
        .Op       (Op),
        .LastStep (LastStep),
        .Halted   (Halted),
        .Illegal  (Illegal)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    endtask

    // Instruction set table: opcode field, condition and sub-field to Op.
    function automatic logic [5:0] ref_op(input logic [15:0] ir);
        casez ({ir[15:11], ir[10:8], ir[1:0]})
            10'b00001_???_??: return 6'h01;
            10'b00010_???_??: return 6'h02;
            10'b00011_???_??: return 6'h03;
            10'b00100_???_??: return 6'h04;
            10'b00101_???_??: return 6'h05;
            10'b00110_???_00: return 6'h06;
            10'b00110_???_01: return 6'h0B;
            10'b00000_???_00: return 6'h07;
            10'b00000_???_01: return 6'h08;
            10'b00000_???_10: return 6'h09;
            10'b00000_???_11: return 6'h0A;
            10'b00111_???_??: return 6'h0C;
            10'b01000_???_??: return 6'h0D;
            10'b01011_???_??: return 6'h0E;
            10'b11000_011_??: return 6'h0F;
            10'b11000_010_??: return 6'h10;
            10'b11000_001_??: return 6'h11;
            10'b11000_000_??: return 6'h12;
            10'b11001_???_??: return 6'h13;
            10'b10000_???_??: return 6'h14;
            10'b10001_???_??: return 6'h15;
            10'b10010_???_??: return 6'h16;
            10'b10011_???_??: return 6'h17;
            10'b11100_???_00: return 6'h18;
            10'b11100_???_01: return 6'h19;
            default:          return 6'h00;
        endcase
    endfunction

    // Number of the final step for a given op.
    function automatic int ref_len(input logic [5:0] op);
        if (op inside {6'h03, 6'h04}) return 4;
        if (op inside {[6'h05:6'h0D], 6'h15, 6'h16}) return 3;
        return 2;
    endfunction

    function automatic logic ref_last();
        return (m_cnt != 0) && (m_cnt == ref_len(ref_op(m_ir))) && !m_halted;
    endfunction

    task automatic model_reset();
        m_cnt    = 0;
        m_ir     = 16'h0000;
        m_halted = 1'b0;
    endtask

    task automatic model_edge(input logic [15:0] md, input logic st);
        logic       fin;
        logic [5:0] op;
        if (!m_halted && !st) begin
            fin = ref_last();
            op  = ref_op(m_ir);
            if (m_cnt == 0) m_ir = md;
            if (fin) begin
                if (op == 6'h19) m_halted = 1'b1;
                m_cnt = 0;
            end else if (m_cnt >= 4) begin
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [5:0] op;
        op = ref_op(m_ir);
        chk("Cnt",      16'(Cnt),      16'(m_cnt));
        chk("LastStep", 16'(LastStep), 16'(ref_last()));
        chk("Halted",   16'(Halted),   16'(m_halted));
        chk("Illegal",  16'(Illegal),  16'((op == 6'h00) && (m_cnt != 0)));
        chk("InsM",     16'(InsM),     16'(m_ir[15:11]));
        chk("InsL",     16'(InsL),     16'(m_ir[1:0]));
        chk("Cond",     16'(Cond),     16'(m_ir[10:8]));
        chk("Op",       16'(Op),       16'(op));
    endtask

    // One clock: drive, check at the falling edge, advance model at the
    // rising edge, return 1 time unit after it.
    task automatic cycle(input logic [15:0] md, input logic st);
        MemData = md;
        Stall   = st;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge(md, st);
        #1;
    endtask

    task automatic run_instr(input logic [15:0] word);
        cycle(word, 1'b0);
        for (int g = 0; g < 8 && m_cnt != 0; g++) cycle(16'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        #1;
        Rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [15:0] pick_word();
        logic [15:0] tbl [0:24] = '{16'h0801, 16'h1000, 16'h1800, 16'h2000, 16'h2800,
                                    16'h3000, 16'h3101, 16'h0000, 16'h0001, 16'h0002,
                                    16'h0003, 16'h3800, 16'h4000, 16'h5800, 16'hC300,
                                    16'hC200, 16'hC100, 16'hC000, 16'hC800, 16'h8000,
                                    16'h8800, 16'h9000, 16'h9800, 16'hE000, 16'hE001};
        int k;
        k = int'($urandom_range(0, 29));
        if (k < 25) return tbl[k] | (16'($urandom) & 16'h00FC);
        return 16'($urandom);
    endfunction

    initial begin
        int halt_cycles;
        Rst     = 1'b1;
        MemData = 16'h0000;
        Stall   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        Rst = 1'b0;

        // Reset state: ADD decoded from zero IR.
        chk("rst_op", 16'(Op), 16'h0007);

        // Async reset mid-instruction at Cnt=3.
        cycle(16'h0003, 1'b0);
        cycle(16'h0000, 1'b0);
        cycle(16'h0000, 1'b0);
        chk("pre_rst_cnt", 16'(Cnt), 16'd3);
        #1;
        Rst = 1'b1;
        #1;
        chk("arst_cnt",    16'(Cnt),    16'd0);
        chk("arst_halted", 16'(Halted), 16'd0);
        chk("arst_insl",   16'(InsL),   16'd0);
        chk("arst_op",     16'(Op),     16'h0007);
        #1;
        Rst = 1'b0;
        model_reset();

        // LHI, LDRri then SUB, BEQ, BCC.
        run_instr(16'h0801);
        run_instr(16'h1800);
        run_instr(16'h0002);
        run_instr(16'hC100);
        run_instr(16'hC300);

        // Stall at fetch for 3 cycles, then CMP.
        repeat (3) cycle(16'h3101, 1'b1);
        run_instr(16'h3101);

        // Stall in the middle of a load, including on its final step.
        cycle(16'h2000, 1'b0);
        repeat (3) cycle(16'h0000, 1'b0);
        repeat (2) cycle(16'h0000, 1'b1);
        cycle(16'h0000, 1'b0);

        // HLT, then 10 idle cycles offering a new word.
        run_instr(16'hE001);
        chk("halt_set", 16'(Halted), 16'd1);
        repeat (10) cycle(16'h0801, 1'b0);
        do_reset();

        // Illegal word runs as a 2-step NOP.
        run_instr(16'hF800);

        // Random instruction stream with random stalls.
        halt_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            if (m_halted) begin
                halt_cycles++;
                if (halt_cycles > 10) begin
                    do_reset();
                    halt_cycles = 0;
                end
            end
            cycle(pick_word(), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ctrl_step_sequencer
`default_nettype wire
